signed_div_seq: RTL and testbench
=================================

Name: signed_div_seq

Overview:
- Multi-cycle signed integer divider controller, l-bit two's complement.
- Sequences the sign datapath:
  - AbsoluteValue on both operands.
  - An l-iteration restoring shift/subtract loop on magnitudes.
  - GiveSign on quotient and remainder.
- Sits beside the ALU as the DIV/REM execution unit and exchanges operands/results with the core via a Start/Ready/Done handshake.

Parameters:
l, 16, operand/result width in bits (lv = l-1)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous active-high reset, sampled on rising clk
Start  input  1  request; accepted only on an edge where Ready=1
A  input  l  signed dividend, sampled on the accepting edge
B  input  l  signed divisor, sampled on the accepting edge
Ready  output  1  high when a new Start will be accepted
Done  output  1  one-cycle pulse, Q/Rem/DivZero valid
Q  output  l  signed quotient, truncated toward zero
Rem  output  l  signed remainder, sign follows dividend
DivZero  output  1  divisor was zero for the current result

Behaviour:
- Reset (rst=1 at an edge): state IDLE; Ready=1; Done=0; Q=0; Rem=0; DivZero=0. Reset overrides everything, including mid-operation. The operation in flight is discarded with no Done.
- FSM states:
  - IDLE:
    - Ready=1.
    - Start=1 -> LOAD. Latch A, B, qsign=A[lv]^B[lv], rsign=A[lv].
  - LOAD (1 cycle):
    - Compute |A|, |B| via AbsoluteValue and load the magnitude registers.
    - Clear the partial remainder; counter = l-1.
    - B==0 -> FIX with the zero flag set; otherwise -> DIV.
  - DIV (exactly l cycles), restoring step per cycle:
    - P = {rem[l-2:0], dividend_msb}; shift the dividend left.
    - If P >= |B| (unsigned, l+1-bit compare): rem = P-|B|, quotient bit = 1. Else rem = P, bit = 0.
    - At counter==0 -> FIX; otherwise decrement the counter.
  - FIX (1 cycle):
    - Q = GiveSign(qsign, qmag); Rem = GiveSign(rsign, rmag).
    - Div-by-zero: Q = all ones, Rem = original A, DivZero = 1.
    - -> IDLE, with Done=1 in the following cycle.
- Latency:
  - Done is high in the cycle after the (l+3)th rising edge counted from and including the accepting edge: 19 edges for l=16.
  - Div-by-zero: Done after 3 edges.
- Done lasts exactly one cycle. Q/Rem/DivZero hold their values until the FIX of the next operation.
- Ready:
  - Falls on the accepting edge and stays low through LOAD/DIV/FIX.
  - Returns high in the Done cycle. A Start in the Done cycle is accepted, giving back-to-back throughput of l+3 cycles.
- Start while Ready=0 is ignored and does not disturb the operation in flight. A, B changing during the operation have no effect.
- Arithmetic/width rules:
  - Magnitudes are unsigned l-bit. |-2^(l-1)| = 2^(l-1) (1000...0).
  - -2^(l-1) / -1: qmag = 2^(l-1), qsign=0 -> Q = 0x8000 (wraps, no trap). Rem = 0.
  - Rem is negated only when non-zero. Inverting 0 yields 0, so no special case is needed.
  - Invariant for B != 0 (excluding the overflow case): A == Q*B + Rem (mod 2^l), |Rem| < |B|.
- Rem/Q are registered outputs, with no combinational path from inputs to outputs.

Test Plan:
- 100/7 (0x0064/0x0007) -> Done at edge 19: Q=0x000E, Rem=0x0002, DivZero=0. Ready low edges 1..18.
- -100/7 (0xFF9C/0x0007) -> Q=0xFFF2 (-14), Rem=0xFFFE (-2). 100/-7 -> Q=0xFFF2, Rem=0x0002. -100/-7 -> Q=0x000E, Rem=0xFFFE.
- Boundaries:
  - 0x8000/0xFFFF -> Q=0x8000, Rem=0x0000.
  - 0x8000/0x0001 -> Q=0x8000, Rem=0.
  - 7/100 -> Q=0, Rem=7.
  - -7/100 -> Q=0, Rem=0xFFF9.
- 5/0 -> Done after 3 edges: Q=0xFFFF, Rem=0x0005, DivZero=1. The next valid divide clears DivZero.
- Start pulsed during DIV with different A/B -> ignored; the original result is returned. Start held high in the Done cycle -> second operation accepted and its Done arrives l+3 edges later.
- rst asserted at the 10th DIV cycle -> next cycle Ready=1, Done=0, Q=Rem=0. No Done pulse for the aborted op. A new 100/7 afterwards completes correctly.

Source files
------------

// File: rtl/signed_div_seq.sv
// signed_div_seq: multi-cycle signed integer divider (DIV/REM execution unit).
//
// Takes the absolute value of both operands, runs an l-iteration restoring
// shift/subtract loop on the magnitudes, then applies the result signs.
// A quotient is truncated toward zero and the remainder takes the sign of the
// dividend. Division by zero yields Q = all ones, Rem = A and DivZero = 1.
//
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous active-high reset
//   Start    operation request, accepted on an edge where Ready = 1
//   A, B     signed dividend / divisor, sampled on the accepting edge
//   Ready    high when a new Start will be accepted (idle)
//   Done     one-cycle pulse; Q/Rem/DivZero valid from this cycle on
//   Q, Rem   registered signed quotient / remainder
//   DivZero  divisor of the current result was zero
//
// Latency: l+3 edges from the accepting edge to the Done cycle (3 edges when
// dividing by zero). A Start during the Done cycle is accepted.
module signed_div_seq #(
    parameter int l = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic [l-1:0] A,
    input  logic [l-1:0] B,
    output logic         Ready,
    output logic         Done,
    output logic [l-1:0] Q,
    output logic [l-1:0] Rem,
    output logic         DivZero
);

    localparam int lv = l - 1;
    localparam int CW = (l > 1) ? $clog2(l) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    logic [1:0]    state;
    logic [l-1:0]  a_reg, b_reg;   // operands as captured at acceptance
    logic [l-1:0]  bmag;           // |B|
    logic [l-1:0]  dvd;            // |A| shifting out, quotient bits shifting in
    logic [l-1:0]  prem;           // partial remainder
    logic [CW-1:0] cnt;
    logic          qsign, rsign, zflag;

    logic [l:0]    p;
    logic          ge;
    logic [l-1:0]  sub;

    function automatic logic [l-1:0] absval(input logic [l-1:0] x);
        // |-2^(l-1)| wraps to 100..0, which is the correct unsigned magnitude.
        return x[l-1] ? ((~x) + 1'b1) : x;
    endfunction

    function automatic logic [l-1:0] givesign(input logic s, input logic [l-1:0] x);
        // Negating zero gives zero, so a zero remainder keeps its value.
        return s ? ((~x) + 1'b1) : x;
    endfunction

    // Restoring step. prem < |B| <= 2^(l-1), so the top bit of prem is always
    // zero and p fits the l+1-bit compare; when p >= |B| the difference is
    // below |B| and fits in l bits.
    assign p   = {prem, dvd[lv]};
    assign ge  = (p >= {1'b0, bmag});
    assign sub = p[l-1:0] - bmag;

    assign Ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            Done    <= 1'b0;
            Q       <= '0;
            Rem     <= '0;
            DivZero <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            bmag    <= '0;
            dvd     <= '0;
            prem    <= '0;
            cnt     <= '0;
            qsign   <= 1'b0;
            rsign   <= 1'b0;
            zflag   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_reg <= A;
                        b_reg <= B;
                        qsign <= A[lv] ^ B[lv];
                        rsign <= A[lv];
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    dvd   <= absval(a_reg);
                    bmag  <= absval(b_reg);
                    prem  <= '0;
                    cnt   <= CW'(l - 1);
                    zflag <= (b_reg == '0);
                    state <= (b_reg == '0) ? FIX : DIV;
                end
                DIV: begin
                    prem <= ge ? sub : p[l-1:0];
                    dvd  <= {dvd[l-2:0], ge};
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    if (zflag) begin
                        Q       <= '1;
                        Rem     <= a_reg;
                        DivZero <= 1'b1;
                    end else begin
                        Q       <= givesign(qsign, dvd);
                        Rem     <= givesign(rsign, prem);
                        DivZero <= 1'b0;
                    end
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_div_seq.sv
// Testbench for signed_div_seq: directed vectors with literal expectations
// plus a cycle-level reference model compared on every falling edge.
module tb_signed_div_seq;

    localparam int L = 16;

    logic         clk = 1'b0;
    logic         rst, Start;
    logic [L-1:0] A, B;
    logic         Ready, Done, DivZero;
    logic [L-1:0] Q, Rem;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    signed_div_seq #(.l(L)) dut (
        .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B),
        .Ready(Ready), .Done(Done), .Q(Q), .Rem(Rem), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic: {dz, q, r}.
    function automatic logic [2*L:0] model_div(input logic [L-1:0] a, input logic [L-1:0] b);
        int sa, sb, q, r;
        logic [31:0] qv, rv;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) return {1'b1, {L{1'b1}}, a};
        q  = sa / sb;   // truncates toward zero
        r  = sa % sb;   // sign follows dividend
        qv = q;
        rv = r;
        return {1'b0, qv[L-1:0], rv[L-1:0]};
    endfunction

    // Cycle model: 'left' counts edges until the Done cycle; idle when zero.
    int           left = 0;
    logic         m_done = 1'b0, m_dz = 1'b0;
    logic [L-1:0] m_q = '0, m_r = '0;
    logic [2*L:0] pending = '0;

    always @(posedge clk) begin
        if (rst) begin
            left   <= 0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dz   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (left == 0) begin
                if (Start) begin
                    pending <= model_div(A, B);
                    left    <= (B == '0) ? 2 : L + 2;
                end
            end else begin
                left <= left - 1;
                if (left == 1) begin
                    m_done <= 1'b1;
                    {m_dz, m_q, m_r} <= pending;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",   32'(Ready),   32'(left == 0));
            check("done",    32'(Done),    32'(m_done));
            check("q",       32'(Q),       32'(m_q));
            check("rem",     32'(Rem),     32'(m_r));
            check("divzero", 32'(DivZero), 32'(m_dz));
        end
    end

    // Present an operation; returns just after the accepting edge.
    task automatic start_op(input logic [L-1:0] a, input logic [L-1:0] b);
        A = a; B = b; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
    endtask

    // Counts edges from the accepting edge to the Done cycle, then checks
    // the literal results. Optionally pulses a stray Start mid-operation.
    task automatic wait_done(input string name, input int lat,
                             input logic [L-1:0] eq, input logic [L-1:0] er,
                             input logic edz, input bit poke);
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (poke && n == 6) begin A = 16'h1234; B = 16'h0003; Start = 1'b1; end
            if (poke && n == 7) begin A = 16'h0000; B = 16'h0000; Start = 1'b0; end
            if (Done) break;
        end
        check({name, "_lat"}, n, lat);
        check({name, "_q"}, 32'(Q), 32'(eq));
        check({name, "_rem"}, 32'(Rem), 32'(er));
        check({name, "_dz"}, 32'(DivZero), 32'(edz));
    endtask

    logic [L-1:0] va [10] = '{16'h0064, 16'hFF9C, 16'h0064, 16'hFF9C, 16'h8000,
                              16'h8000, 16'h0007, 16'hFFF9, 16'h0005, 16'h0064};
    logic [L-1:0] vb [10] = '{16'h0007, 16'h0007, 16'hFFF9, 16'hFFF9, 16'hFFFF,
                              16'h0001, 16'h0064, 16'h0064, 16'h0000, 16'h0007};
    logic [L-1:0] vq [10] = '{16'h000E, 16'hFFF2, 16'hFFF2, 16'h000E, 16'h8000,
                              16'h8000, 16'h0000, 16'h0000, 16'hFFFF, 16'h000E};
    logic [L-1:0] vr [10] = '{16'h0002, 16'hFFFE, 16'h0002, 16'hFFFE, 16'h0000,
                              16'h0000, 16'h0007, 16'hFFF9, 16'h0005, 16'h0002};
    logic         vz [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        int nd;
        rst = 1'b1; Start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(Ready), 1);
        check("rst_done", 32'(Done), 0);
        check("rst_q", 32'(Q), 0);
        check("rst_rem", 32'(Rem), 0);
        check("rst_dz", 32'(DivZero), 0);

        // Directed table; the last entry (after 5/0) shows DivZero clearing.
        for (int i = 0; i < 10; i++) begin
            start_op(va[i], vb[i]);
            wait_done($sformatf("vec%0d", i), vz[i] ? 3 : L + 3, vq[i], vr[i], vz[i], 1'b0);
            @(negedge clk);
        end

        // Stray Start with different operands during DIV is ignored.
        start_op(16'hFF9C, 16'h0007);
        wait_done("poke", L + 3, 16'hFFF2, 16'hFFFE, 1'b0, 1'b1);

        // Back-to-back: Start held in the Done cycle is accepted.
        start_op(16'h0064, 16'h0007);
        wait_done("b2b1", L + 3, 16'h000E, 16'h0002, 1'b0, 1'b0);
        start_op(16'h0007, 16'hFF9C);
        wait_done("b2b2", L + 3, 16'h0000, 16'h0007, 1'b0, 1'b0);

        // Reset mid-DIV: no Done for the aborted op, outputs cleared.
        @(negedge clk);
        start_op(16'h0064, 16'h0007);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(Ready), 1);
        check("abort_done", 32'(Done), 0);
        check("abort_q", 32'(Q), 0);
        check("abort_rem", 32'(Rem), 0);
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            if (Done) nd++;
        end
        check("abort_no_done", nd, 0);
        start_op(16'h0064, 16'h0007);
        wait_done("after_rst", L + 3, 16'h000E, 16'h0002, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
